uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
- Multicycle control unit FSM for the 64-bit RISC-V datapath; sits directly upstream of it.
- Consumes the opcode/funct fields from the instruction register and the ULA comparison flag.
- Drives every datapath enable and mux select: PC write, IR load, register-bank write, data-memory write, ULA operation and the mux selects.
- Supported subset: R-type add/sub/and/or, addi, ld, sd, beq, bne, lui. Any other opcode traps.

Parameters:
- FETCH_WAIT, 1, cycles between PC presentation and valid instruction-memory data (synchronous read). Legal values 1..3.
- DMEM_WAIT, 1, cycles between address presentation and valid data-memory read data. Legal values 1..3.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- Op  in  7  instruction bits [6:0].
- Funct3  in  3  instruction bits [14:12].
- Funct7_5  in  1  instruction bit [30].
- igual  in  1  ULA equality flag (A == B).
- PC_Write  out  1  PC load enable.
- PC_Src  out  1  PC input select: 0 = ULA result (PC+4), 1 = Reg_ULAOut (branch target).
- Seletor_Ula  out  3  ULA operation: 001 ADD, 010 SUB, 011 AND, 100 OR, 000 pass B.
- mux_A_seletor  out  3  ULA A select: 0 = PC, 1 = Reg_A, 2 = zero.
- mux_B_seletor  out  3  ULA B select: 0 = Reg_B, 1 = constant 4, 2 = sign-extended imm, 3 = imm<<1.
- register_Inst_wr  out  1  IR load enable.
- Load_AB  out  1  Reg_A/Reg_B load enable.
- Load_ULAOut  out  1  Reg_ULAOut load enable.
- Load_MDR  out  1  memory data register load enable.
- Data_Memory_wr  out  1  data-memory write enable.
- bancoRegisters_wr  out  1  register-bank write enable.
- Mux_Banco_Reg_Seletor  out  3  write-back select: 0 = Reg_ULAOut, 1 = MDR.
- Trap  out  1  sticky illegal-opcode flag.
- Estado  out  4  current FSM state code, for debug.

Behaviour:
- Output style: Moore. All outputs are decoded from the registered state only, except PC_Write in BRANCH (see below).
- Default value of every output is 0 whenever the state does not assert it.
- Reset: while reset = 0, state = FETCH, wait counter = 0, Trap = 0, all enables 0. Reset asserted mid-instruction aborts it; no write of any kind occurs in the cycle where reset is low.
- State encodings: FETCH = 0, FETCH_WAIT = 1, DECODE = 2, EXEC_R = 3, EXEC_I = 4, MEM_ADDR = 5, MEM_RD = 6, MEM_WAIT = 7, WB_LOAD = 8, MEM_WR = 9, WB_ALU = 10, BRANCH = 11, LUI = 12, TRAP = 15.
- FETCH: instruction memory is addressed by PC. Load the wait counter with FETCH_WAIT-1 and go to FETCH_WAIT.
- FETCH_WAIT: decrement the counter each cycle. When the counter is 0:
  - register_Inst_wr = 1; PC_Write = 1; PC_Src = 0; mux A = PC; mux B = 4; ULA = ADD.
  - Go to DECODE.
- DECODE: Load_AB = 1; Load_ULAOut = 1 with PC + (imm<<1) (mux A = 0, mux B = 3, ADD). Next state by Op:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - any other value -> TRAP
- EXEC_R: mux A = 1, mux B = 0, Load_ULAOut = 1. Operation by Funct3/Funct7_5:
  - 000/0 -> ADD
  - 000/1 -> SUB
  - 111/x -> AND
  - 110/x -> OR
  - any other combination -> TRAP
  - Go to WB_ALU.
- EXEC_I: mux A = 1, mux B = 2, ADD, Load_ULAOut = 1. Go to WB_ALU.
- WB_ALU: bancoRegisters_wr = 1, write-back select = 0. Go to FETCH.
- MEM_ADDR: A + imm (mux A = 1, mux B = 2, ADD), Load_ULAOut = 1. Go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: load the wait counter with DMEM_WAIT-1. Go to MEM_WAIT.
- MEM_WAIT: count down; at 0, Load_MDR = 1. Go to WB_LOAD.
- WB_LOAD: bancoRegisters_wr = 1, write-back select = 1. Go to FETCH.
- MEM_WR: Data_Memory_wr = 1 for exactly one cycle. Go to FETCH.
- BRANCH:
  - mux A = 1, mux B = 0, SUB.
  - PC_Src = 1. PC_Write = igual for beq (Funct3 000), ~igual for bne (Funct3 001).
  - Any other Funct3 -> TRAP with no PC write.
  - Go to FETCH.
- LUI: mux A = 2, mux B = 2, ADD, Load_ULAOut = 1. Go to WB_ALU.
- TRAP: Trap = 1, all enables 0. Stays in TRAP until reset.
- Latencies with FETCH_WAIT = DMEM_WAIT = 1: R-type 4 cycles, addi 4, lui 4, sd 4, beq/bne 3, ld 6. Each additional wait cycle adds 1.
- At most one of {register_Inst_wr, bancoRegisters_wr, Data_Memory_wr} is high in any cycle.

Optional Feature:
- Macro: UC_PERF_CNT_EN.
- Defined:
  - Adds output Instr_Retiradas [31:0], incremented on every transition into FETCH from WB_ALU, WB_LOAD, MEM_WR or BRANCH.
  - Wraps from 0xFFFFFFFF to 0. Cleared by reset. Frozen in TRAP.
- Undefined: the port and the counter are absent. FSM behaviour is identical.

Test Plan:
- Reset low for 3 cycles, then high, Op = 0110011, Funct3 = 000, Funct7_5 = 0 -> Estado 0,1,2,3,10,0. bancoRegisters_wr high only in the 5th cycle; Seletor_Ula = 001 in EXEC_R.
- ld (Op = 0000011), DMEM_WAIT = 2 -> Load_MDR pulses exactly once, 2 cycles after MEM_RD is entered; WB_LOAD asserts write-back select = 1; total 7 cycles.
- beq with igual = 1, then beq with igual = 0 -> PC_Write with PC_Src = 1 in BRANCH for the first only. bne with igual = 0 -> PC_Write = 1 in BRANCH.
- Op = 1111111 -> DECODE goes to TRAP; Trap = 1 and all enables 0 for 20 cycles; reset pulse returns to FETCH with Trap = 0.
- sd issued, reset driven low during the MEM_ADDR cycle -> Data_Memory_wr never asserts; after release the FSM starts in FETCH.
- With UC_PERF_CNT_EN: 5 addi plus 1 sd -> Instr_Retiradas = 6. Counter preset near wrap via a force to 0xFFFFFFFF, then 1 instruction -> 0.

Source files
------------

// File: rtl/uc_multiciclo.sv
// Multicycle control FSM for the 64-bit RISC-V datapath. Moore decode of the state register; fetch/dmem waits are parameterised.
// Optional retired-instruction counter (Instr_Retiradas) is built only when UC_PERF_CNT_EN is defined.
module uc_multiciclo #(
    parameter int FETCH_WAIT = 1,
    parameter int DMEM_WAIT  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7_5,
    input  logic       igual,
    output logic       PC_Write,
    output logic       PC_Src,
    output logic [2:0] Seletor_Ula,
    output logic [2:0] mux_A_seletor,
    output logic [2:0] mux_B_seletor,
    output logic       register_Inst_wr,
    output logic       Load_AB,
    output logic       Load_ULAOut,
    output logic       Load_MDR,
    output logic       Data_Memory_wr,
    output logic       bancoRegisters_wr,
    output logic [2:0] Mux_Banco_Reg_Seletor,
    output logic       Trap,
    output logic [3:0] Estado
`ifdef UC_PERF_CNT_EN
    ,
    output logic [31:0] Instr_Retiradas
`endif
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_EXEC_R     = 4'd3,
        S_EXEC_I     = 4'd4,
        S_MEM_ADDR   = 4'd5,
        S_MEM_RD     = 4'd6,
        S_MEM_WAIT   = 4'd7,
        S_WB_LOAD    = 4'd8,
        S_MEM_WR     = 4'd9,
        S_WB_ALU     = 4'd10,
        S_BRANCH     = 4'd11,
        S_LUI        = 4'd12,
        S_TRAP       = 4'd15
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ULA_PASS = 3'b000;
    localparam logic [2:0] ULA_ADD  = 3'b001;
    localparam logic [2:0] ULA_SUB  = 3'b010;
    localparam logic [2:0] ULA_AND  = 3'b011;
    localparam logic [2:0] ULA_OR   = 3'b100;

    localparam logic [1:0] FW_LOAD = 2'(FETCH_WAIT - 1);
    localparam logic [1:0] DW_LOAD = 2'(DMEM_WAIT - 1);

    state_t     state;
    logic [1:0] cnt;
    logic [2:0] r_op;
    logic       r_legal;
    logic       br_legal;
    logic       br_take;

    always_comb begin
        r_op    = ULA_PASS;
        r_legal = 1'b1;
        casez ({Funct3, Funct7_5})
            4'b0000: r_op = ULA_ADD;
            4'b0001: r_op = ULA_SUB;
            4'b111?: r_op = ULA_AND;
            4'b110?: r_op = ULA_OR;
            default: r_legal = 1'b0;
        endcase
    end

    // Only beq (000) and bne (001) are legal; Funct3[0] selects the sense of the test.
    assign br_legal = (Funct3[2:1] == 2'b00);
    assign br_take  = Funct3[0] ? ~igual : igual;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            cnt   <= 2'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    cnt   <= FW_LOAD;
                    state <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (cnt == 2'd0) state <= S_DECODE;
                    else             cnt   <= cnt - 2'd1;
                end
                S_DECODE: begin
                    case (Op)
                        OP_R:         state <= S_EXEC_R;
                        OP_I:         state <= S_EXEC_I;
                        OP_LD, OP_SD: state <= S_MEM_ADDR;
                        OP_BR:        state <= S_BRANCH;
                        OP_LUI:       state <= S_LUI;
                        default:      state <= S_TRAP;
                    endcase
                end
                S_EXEC_R:   state <= r_legal ? S_WB_ALU : S_TRAP;
                S_EXEC_I:   state <= S_WB_ALU;
                S_LUI:      state <= S_WB_ALU;
                S_MEM_ADDR: state <= (Op == OP_LD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    cnt   <= DW_LOAD;
                    state <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (cnt == 2'd0) state <= S_WB_LOAD;
                    else             cnt   <= cnt - 2'd1;
                end
                S_WB_LOAD, S_WB_ALU, S_MEM_WR: state <= S_FETCH;
                S_BRANCH:   state <= br_legal ? S_FETCH : S_TRAP;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_TRAP;
            endcase
        end
    end

`ifdef UC_PERF_CNT_EN
    logic        retire;
    logic [31:0] instr_ret;

    assign retire = (state == S_WB_ALU) || (state == S_WB_LOAD) || (state == S_MEM_WR) ||
                    ((state == S_BRANCH) && br_legal);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      instr_ret <= 32'd0;
        else if (retire) instr_ret <= instr_ret + 32'd1;
    end

    assign Instr_Retiradas = instr_ret;
`endif

    always_comb begin
        PC_Write              = 1'b0;
        PC_Src                = 1'b0;
        Seletor_Ula           = ULA_PASS;
        mux_A_seletor         = 3'd0;
        mux_B_seletor         = 3'd0;
        register_Inst_wr      = 1'b0;
        Load_AB               = 1'b0;
        Load_ULAOut           = 1'b0;
        Load_MDR              = 1'b0;
        Data_Memory_wr        = 1'b0;
        bancoRegisters_wr     = 1'b0;
        Mux_Banco_Reg_Seletor = 3'd0;
        Trap                  = 1'b0;
        case (state)
            S_FETCH_WAIT: begin
                if (cnt == 2'd0) begin
                    register_Inst_wr = 1'b1;
                    PC_Write         = 1'b1;
                    Seletor_Ula      = ULA_ADD;
                    mux_B_seletor    = 3'd1;
                end
            end
            S_DECODE: begin
                Load_AB       = 1'b1;
                Load_ULAOut   = 1'b1;
                mux_B_seletor = 3'd3;
                Seletor_Ula   = ULA_ADD;
            end
            S_EXEC_R: begin
                mux_A_seletor = 3'd1;
                Load_ULAOut   = 1'b1;
                Seletor_Ula   = r_op;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                mux_A_seletor = 3'd1;
                mux_B_seletor = 3'd2;
                Seletor_Ula   = ULA_ADD;
                Load_ULAOut   = 1'b1;
            end
            S_MEM_WAIT: Load_MDR = (cnt == 2'd0);
            S_WB_LOAD: begin
                bancoRegisters_wr     = 1'b1;
                Mux_Banco_Reg_Seletor = 3'd1;
            end
            S_MEM_WR: Data_Memory_wr    = 1'b1;
            S_WB_ALU: bancoRegisters_wr = 1'b1;
            S_BRANCH: begin
                mux_A_seletor = 3'd1;
                Seletor_Ula   = ULA_SUB;
                PC_Src        = 1'b1;
                PC_Write      = br_legal & br_take;
            end
            S_LUI: begin
                mux_A_seletor = 3'd2;
                mux_B_seletor = 3'd2;
                Seletor_Ula   = ULA_ADD;
                Load_ULAOut   = 1'b1;
            end
            S_TRAP: Trap = 1'b1;
            default: ;
        endcase
    end

    assign Estado = state;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: directed table of instructions, hand-written reset/trap sequences, and random instructions
// checked cycle-by-cycle against a per-instruction expected-trace model.
module tb_uc_multiciclo;
    localparam int FW = 1;
    localparam int DW = 2;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef struct packed {
        logic       pcw;
        logic       pcs;
        logic [2:0] ula;
        logic [2:0] ma;
        logic [2:0] mb;
        logic       irw;
        logic       lab;
        logic       lulo;
        logic       lmdr;
        logic       dmw;
        logic       rbw;
        logic [2:0] wbs;
        logic       trap;
        logic [3:0] st;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       ig;
        int         lat;
        int         n_pcw;
        int         n_rbw;
        int         n_dmw;
        int         n_mdr;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] Op = '0;
    logic [2:0] Funct3 = '0;
    logic       Funct7_5 = 1'b0;
    logic       igual = 1'b0;
    logic       PC_Write, PC_Src, register_Inst_wr, Load_AB, Load_ULAOut, Load_MDR;
    logic       Data_Memory_wr, bancoRegisters_wr, Trap;
    logic [2:0] Seletor_Ula, mux_A_seletor, mux_B_seletor, Mux_Banco_Reg_Seletor;
    logic [3:0] Estado;
`ifdef UC_PERF_CNT_EN
    logic [31:0] instr_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    cyc_t exp_q[$];
    cyc_t act;
    logic watch_dmw = 1'b0;
    logic dmw_seen  = 1'b0;

    uc_multiciclo #(.FETCH_WAIT(FW), .DMEM_WAIT(DW)) dut (
        .clock(clock), .reset(reset), .Op(Op), .Funct3(Funct3), .Funct7_5(Funct7_5), .igual(igual),
        .PC_Write(PC_Write), .PC_Src(PC_Src), .Seletor_Ula(Seletor_Ula),
        .mux_A_seletor(mux_A_seletor), .mux_B_seletor(mux_B_seletor),
        .register_Inst_wr(register_Inst_wr), .Load_AB(Load_AB), .Load_ULAOut(Load_ULAOut),
        .Load_MDR(Load_MDR), .Data_Memory_wr(Data_Memory_wr), .bancoRegisters_wr(bancoRegisters_wr),
        .Mux_Banco_Reg_Seletor(Mux_Banco_Reg_Seletor), .Trap(Trap), .Estado(Estado)
`ifdef UC_PERF_CNT_EN
        , .Instr_Retiradas(instr_cnt)
`endif
    );

    always #5 clock = ~clock;

    assign act = {PC_Write, PC_Src, Seletor_Ula, mux_A_seletor, mux_B_seletor, register_Inst_wr,
                  Load_AB, Load_ULAOut, Load_MDR, Data_Memory_wr, bancoRegisters_wr,
                  Mux_Banco_Reg_Seletor, Trap, Estado};

    always @(posedge clock or negedge reset)
        if (watch_dmw && Data_Memory_wr) dmw_seen <= 1'b1;

    function automatic cyc_t z(input int st);
        cyc_t c;
        c = '0;
        c.st = 4'(st);
        return c;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input cyc_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h (Estado %0d) expected %h (Estado %0d)", name, act, act.st, e, e.st);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Expected per-cycle outputs for one instruction, from FETCH until the cycle before the next FETCH.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic ig,
                         input int ntrap, output bit traps);
        cyc_t c;
        exp_q.delete();
        traps = 0;
        exp_q.push_back(z(0));
        for (int i = 0; i < FW - 1; i++) exp_q.push_back(z(1));
        c = z(1); c.irw = 1; c.pcw = 1; c.ula = 3'd1; c.mb = 3'd1; exp_q.push_back(c);
        c = z(2); c.lab = 1; c.lulo = 1; c.mb = 3'd3; c.ula = 3'd1; exp_q.push_back(c);
        case (op)
            OP_R: begin
                c = z(3); c.ma = 3'd1; c.lulo = 1;
                if (f3 == 0 && !f7)  c.ula = 3'd1;
                else if (f3 == 0)    c.ula = 3'd2;
                else if (f3 == 7)    c.ula = 3'd3;
                else if (f3 == 6)    c.ula = 3'd4;
                else                 traps = 1;
                exp_q.push_back(c);
            end
            OP_I: begin
                c = z(4); c.ma = 3'd1; c.mb = 3'd2; c.ula = 3'd1; c.lulo = 1; exp_q.push_back(c);
            end
            OP_LUI: begin
                c = z(12); c.ma = 3'd2; c.mb = 3'd2; c.ula = 3'd1; c.lulo = 1; exp_q.push_back(c);
            end
            OP_LD, OP_SD: begin
                c = z(5); c.ma = 3'd1; c.mb = 3'd2; c.ula = 3'd1; c.lulo = 1; exp_q.push_back(c);
                if (op == OP_LD) begin
                    exp_q.push_back(z(6));
                    for (int i = 0; i < DW - 1; i++) exp_q.push_back(z(7));
                    c = z(7); c.lmdr = 1; exp_q.push_back(c);
                    c = z(8); c.rbw = 1; c.wbs = 3'd1; exp_q.push_back(c);
                end else begin
                    c = z(9); c.dmw = 1; exp_q.push_back(c);
                end
            end
            OP_BR: begin
                c = z(11); c.ma = 3'd1; c.ula = 3'd2; c.pcs = 1;
                if (f3 == 0)      c.pcw = ig;
                else if (f3 == 1) c.pcw = !ig;
                else              traps = 1;
                exp_q.push_back(c);
            end
            default: traps = 1;
        endcase
        if (!traps && (op == OP_R || op == OP_I || op == OP_LUI)) begin
            c = z(10); c.rbw = 1; exp_q.push_back(c);
        end
        if (traps)
            for (int i = 0; i < ntrap; i++) begin
                c = z(15); c.trap = 1; exp_q.push_back(c);
            end
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic ig, input int ntrap, output bit traps);
        Op = op; Funct3 = f3; Funct7_5 = f7; igual = ig;
        build(op, f3, f7, ig, ntrap, traps);
        foreach (exp_q[i]) begin
            check($sformatf("%s cyc%0d", name, i), exp_q[i]);
            step();
        end
    endtask

    // Assumes we are 1ns after a rising edge; leaves us there with reset released.
    task automatic do_reset(input string name);
        reset = 1'b0;
        #1;
        check({name, " asserted"}, z(0));
        repeat (3) step();
        check({name, " held"}, z(0));
        reset = 1'b1;
    endtask

    initial begin
        vec_t tbl[12];
        bit   tr;
        int   lat, npcw, nrbw, ndmw, nmdr;

        tbl[0]  = '{OP_R,   3'd0, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        tbl[1]  = '{OP_R,   3'd0, 1'b1, 1'b0, 4, 1, 1, 0, 0};
        tbl[2]  = '{OP_R,   3'd7, 1'b1, 1'b0, 4, 1, 1, 0, 0};
        tbl[3]  = '{OP_R,   3'd6, 1'b0, 1'b1, 4, 1, 1, 0, 0};
        tbl[4]  = '{OP_I,   3'd0, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        tbl[5]  = '{OP_LUI, 3'd3, 1'b1, 1'b0, 4, 1, 1, 0, 0};
        tbl[6]  = '{OP_LD,  3'd3, 1'b0, 1'b0, 7, 1, 1, 0, 1};
        tbl[7]  = '{OP_SD,  3'd3, 1'b0, 1'b1, 4, 1, 0, 1, 0};
        tbl[8]  = '{OP_BR,  3'd0, 1'b0, 1'b1, 3, 2, 0, 0, 0};
        tbl[9]  = '{OP_BR,  3'd0, 1'b0, 1'b0, 3, 1, 0, 0, 0};
        tbl[10] = '{OP_BR,  3'd1, 1'b0, 1'b0, 3, 2, 0, 0, 0};
        tbl[11] = '{OP_BR,  3'd1, 1'b0, 1'b1, 3, 1, 0, 0, 0};

        @(posedge clock); #1;
        do_reset("initial reset");
        run_instr("add after reset", OP_R, 3'd0, 1'b0, 1'b0, 0, tr);
        check_val("back in FETCH after add", int'(Estado), 0);

        foreach (tbl[k]) begin
            Op = tbl[k].op; Funct3 = tbl[k].f3; Funct7_5 = tbl[k].f7; igual = tbl[k].ig;
            lat = 0; npcw = 0; nrbw = 0; ndmw = 0; nmdr = 0;
            step();
            while (Estado != 4'd0 && lat < 30) begin
                npcw += int'(PC_Write); nrbw += int'(bancoRegisters_wr);
                ndmw += int'(Data_Memory_wr); nmdr += int'(Load_MDR);
                check_val($sformatf("vec%0d write one-hot", k),
                          int'(register_Inst_wr) + int'(bancoRegisters_wr) + int'(Data_Memory_wr) <= 1, 1);
                lat++;
                step();
            end
            check_val($sformatf("vec%0d latency", k), lat, tbl[k].lat);
            check_val($sformatf("vec%0d PC_Write pulses", k), npcw, tbl[k].n_pcw);
            check_val($sformatf("vec%0d regbank writes", k), nrbw, tbl[k].n_rbw);
            check_val($sformatf("vec%0d dmem writes", k), ndmw, tbl[k].n_dmw);
            check_val($sformatf("vec%0d MDR loads", k), nmdr, tbl[k].n_mdr);
        end

        run_instr("ld trace", OP_LD, 3'd3, 1'b0, 1'b0, 0, tr);
        run_instr("beq taken", OP_BR, 3'd0, 1'b0, 1'b1, 0, tr);
        run_instr("beq not taken", OP_BR, 3'd0, 1'b0, 1'b0, 0, tr);
        run_instr("bne taken", OP_BR, 3'd1, 1'b0, 1'b0, 0, tr);
        run_instr("bad branch", OP_BR, 3'd4, 1'b0, 1'b1, 3, tr);
        do_reset("reset after bad branch");
        run_instr("bad R funct", OP_R, 3'd2, 1'b0, 1'b0, 3, tr);
        do_reset("reset after bad R");

        run_instr("illegal op", 7'b1111111, 3'd0, 1'b0, 1'b1, 20, tr);
        do_reset("reset from TRAP");
        check("Trap cleared after reset", z(0));
        run_instr("addi after trap", OP_I, 3'd0, 1'b0, 1'b0, 0, tr);

        watch_dmw = 1'b1;
        Op = OP_SD; Funct3 = 3'd3; Funct7_5 = 1'b0; igual = 1'b0;
        repeat (2 + FW) step();
        check_val("sd reached MEM_ADDR", int'(Estado), 5);
        do_reset("reset in MEM_ADDR");
        watch_dmw = 1'b0;
        check_val("no store after abort", int'(dmw_seen), 0);
        run_instr("addi after abort", OP_I, 3'd0, 1'b0, 1'b0, 0, tr);

        for (int it = 0; it < 60; it++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LD;
                3: op = OP_SD;
                4: op = OP_BR;
                5: op = OP_LUI;
                6: op = 7'($urandom_range(0, 127));
                default: op = OP_R;
            endcase
            f3 = 3'($urandom_range(0, 7));
            if (op == OP_R && $urandom_range(0, 3) != 0) f3 = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd6;
            if (op == OP_BR && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
            run_instr($sformatf("rand%0d op=%b f3=%0d", it, op, f3), op, f3,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, tr);
            if (tr) do_reset("reset after random trap");
        end

`ifdef UC_PERF_CNT_EN
        do_reset("perf reset");
        check_val("perf cleared", int'(instr_cnt), 0);
        for (int i = 0; i < 5; i++) run_instr("perf addi", OP_I, 3'd0, 1'b0, 1'b0, 0, tr);
        run_instr("perf sd", OP_SD, 3'd3, 1'b0, 1'b0, 0, tr);
        check_val("perf count 6", int'(instr_cnt), 6);
        force dut.instr_ret = 32'hFFFF_FFFF;
        #1;
        release dut.instr_ret;
        run_instr("perf wrap addi", OP_I, 3'd0, 1'b0, 1'b0, 0, tr);
        check_val("perf wrap to 0", int'(instr_cnt), 0);
`endif

        check_val("final state FETCH", int'(Estado), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
